// File: rtl/rf_pkg.sv
// Register-file shared types: address/data typedefs, writeback source encoding.
package rf_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;

    typedef logic [REG_AW-1:0] RegAddr;
    typedef logic [XLEN-1:0]   Word;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } Source;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Issue, writeback handshake, register-file write port and hazard query bundle.
interface writeback_arbiter_if
    import rf_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic            i_issue_valid;
    RegAddr          i_issue_rd;
    logic            i_issue_src;

    logic            i_alu_valid;
    logic            o_alu_ready;
    RegAddr          i_alu_rd;
    logic [XLEN-1:0] i_alu_data;

    logic            i_lsu_valid;
    logic            o_lsu_ready;
    RegAddr          i_lsu_rd;
    logic [XLEN-1:0] i_lsu_data;

    logic            o_w_reg_enable;
    RegAddr          o_w_reg;
    logic [XLEN-1:0] o_w_data;

    RegAddr          i_r_reg_a;
    RegAddr          i_r_reg_b;
    logic            o_busy_a;
    logic            o_busy_b;

    // Requester side: decode plus the two writeback sources.
    modport master (
        output i_issue_valid, i_issue_rd, i_issue_src,
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_lsu_valid, i_lsu_rd, i_lsu_data,
        output i_r_reg_a, i_r_reg_b,
        input  o_alu_ready, o_lsu_ready,
        input  o_w_reg_enable, o_w_reg, o_w_data,
        input  o_busy_a, o_busy_b
    );

    // Arbiter side.
    modport slave (
        input  i_issue_valid, i_issue_rd, i_issue_src,
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_lsu_valid, i_lsu_rd, i_lsu_data,
        input  i_r_reg_a, i_r_reg_b,
        output o_alu_ready, o_lsu_ready,
        output o_w_reg_enable, o_w_reg, o_w_data,
        output o_busy_a, o_busy_b
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; grants are one-hot and combinational.
module rr_arbiter2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    Source last_grant;

    // Reset to LSU so the ALU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_LSU;
        end else if (advance) begin
            last_grant <= grant[1] ? SRC_LSU : SRC_ALU;
        end
    end

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = (last_grant == SRC_LSU) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the register-file write port between ALU and LSU writeback and tracks
// pending writes per register for decode-stage RAW hazard detection.
module writeback_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned XLEN = 32
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    writeback_arbiter_if.slave bus
);

    logic [1:0]          req;
    logic [1:0]          grant;
    logic                transfer;
    logic                win_lsu;
    RegAddr              win_rd;
    logic [XLEN-1:0]     win_data;

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] owner;
    logic [NUM_REGS-1:0] owner_d;

    logic                w_reg_enable;
    RegAddr              w_reg;
    logic [XLEN-1:0]     w_data;

    assign req = {bus.i_lsu_valid, bus.i_alu_valid};

    rr_arbiter2 u_arb (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .req     (req),
        .advance (transfer),
        .grant   (grant)
    );

    assign transfer        = |grant;
    assign bus.o_alu_ready = grant[0];
    assign bus.o_lsu_ready = grant[1];

    assign win_lsu  = grant[1];
    assign win_rd   = win_lsu ? bus.i_lsu_rd   : bus.i_alu_rd;
    assign win_data = win_lsu ? bus.i_lsu_data : bus.i_alu_data;

    // Clear only when the owning source lands; a same-cycle issue overrides the clear.
    always_comb begin
        pending_d = pending;
        owner_d   = owner;
        if (transfer && (win_rd != '0) && (owner[win_rd] == win_lsu)) begin
            pending_d[win_rd] = 1'b0;
        end
        if (bus.i_issue_valid && (bus.i_issue_rd != '0)) begin
            pending_d[bus.i_issue_rd] = 1'b1;
            owner_d[bus.i_issue_rd]   = bus.i_issue_src;
        end
    end

    // Owner reset value of zero encodes SRC_ALU.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending <= '0;
            owner   <= '0;
        end else begin
            pending <= pending_d;
            owner   <= owner_d;
        end
    end

    // x0 writes are accepted but never enabled at the register file.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_reg_enable <= 1'b0;
            w_reg        <= '0;
            w_data       <= '0;
        end else if (transfer) begin
            w_reg_enable <= (win_rd != '0);
            w_reg        <= win_rd;
            w_data       <= win_data;
        end else begin
            w_reg_enable <= 1'b0;
        end
    end

    assign bus.o_w_reg_enable = w_reg_enable;
    assign bus.o_w_reg        = w_reg;
    assign bus.o_w_data       = w_data;

    assign bus.o_busy_a = (bus.i_r_reg_a != '0) && pending[bus.i_r_reg_a];
    assign bus.o_busy_b = (bus.i_r_reg_b != '0) && pending[bus.i_r_reg_b];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed-vector bench for writeback_arbiter with a queue-based write-port monitor.
module tb_writeback_arbiter;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    wr_t  exp_q[$];

    writeback_arbiter_if #(.XLEN(32)) bus ();

    writeback_arbiter #(.XLEN(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic wr_t mk(input logic [4:0] rd, input logic [31:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        return w;
    endfunction

    // Monitor: every enabled write must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.o_w_reg_enable) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got reg %0d data 0x%0h expected no write",
                         bus.o_w_reg, bus.o_w_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("w_reg", 32'(bus.o_w_reg), 32'(e.rd));
                check("w_data", bus.o_w_data, e.data);
            end
        end
    end

    a_alu_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.i_alu_valid && !bus.o_alu_ready) |=>
        (bus.i_alu_valid && $stable(bus.i_alu_rd) && $stable(bus.i_alu_data)))
        else begin
            n_bad++;
            $display("FAIL alu_hold: got unstable ALU request expected stable until ready");
        end

    a_lsu_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.i_lsu_valid && !bus.o_lsu_ready) |=>
        (bus.i_lsu_valid && $stable(bus.i_lsu_rd) && $stable(bus.i_lsu_data)))
        else begin
            n_bad++;
            $display("FAIL lsu_hold: got unstable LSU request expected stable until ready");
        end

    task automatic issue(input logic [4:0] rd, input logic src);
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rd    = rd;
        bus.i_issue_src   = src;
        tick();
        bus.i_issue_valid = 1'b0;
    endtask

    task automatic alu_wb(input logic [4:0] rd, input logic [31:0] data);
        bus.i_alu_valid = 1'b1;
        bus.i_alu_rd    = rd;
        bus.i_alu_data  = data;
        tick();
        bus.i_alu_valid = 1'b0;
    endtask

    task automatic lsu_wb(input logic [4:0] rd, input logic [31:0] data);
        bus.i_lsu_valid = 1'b1;
        bus.i_lsu_rd    = rd;
        bus.i_lsu_data  = data;
        tick();
        bus.i_lsu_valid = 1'b0;
    endtask

    task automatic check_all_idle_busy();
        for (int i = 0; i < 32; i++) begin
            bus.i_r_reg_a = 5'(i);
            bus.i_r_reg_b = 5'(31 - i);
            #1;
            check("busy_a_after_reset", 32'(bus.o_busy_a), 32'd0);
            check("busy_b_after_reset", 32'(bus.o_busy_b), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] exp_alu_rdy;
        logic [7:0] exp_lsu_rdy;
        int         ai;
        int         li;
        int         k;
        logic       ga;
        logic       gl;

        rst_n             = 1'b0;
        bus.i_issue_valid = 1'b0;
        bus.i_issue_rd    = '0;
        bus.i_issue_src   = 1'b0;
        bus.i_alu_valid   = 1'b0;
        bus.i_alu_rd      = '0;
        bus.i_alu_data    = '0;
        bus.i_lsu_valid   = 1'b0;
        bus.i_lsu_rd      = '0;
        bus.i_lsu_data    = '0;
        bus.i_r_reg_a     = 5'd1;
        bus.i_r_reg_b     = 5'd2;

        // Reset values
        @(negedge clk);
        check("rst_w_en", 32'(bus.o_w_reg_enable), 32'd0);
        check("rst_w_reg", 32'(bus.o_w_reg), 32'd0);
        check("rst_w_data", bus.o_w_data, 32'd0);
        check("rst_busy_a", 32'(bus.o_busy_a), 32'd0);
        check("rst_busy_b", 32'(bus.o_busy_b), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_alu_ready", 32'(bus.o_alu_ready), 32'd0);
        check("idle_lsu_ready", 32'(bus.o_lsu_ready), 32'd0);
        tick();

        // Contention: ALU rd 1..4 vs LSU rd 9..12, alternating from ALU
        exp_alu_rdy = 8'b0101_0101;
        exp_lsu_rdy = 8'b1010_1010;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(5'(1 + i), 32'hA000_0000 + 32'(1 + i)));
            exp_q.push_back(mk(5'(9 + i), 32'hB000_0000 + 32'(9 + i)));
        end
        ai = 0;
        li = 0;
        k  = 0;
        bus.i_alu_valid = 1'b1;
        bus.i_alu_rd    = 5'd1;
        bus.i_alu_data  = 32'hA000_0001;
        bus.i_lsu_valid = 1'b1;
        bus.i_lsu_rd    = 5'd9;
        bus.i_lsu_data  = 32'hB000_0009;
        while ((ai < 4 || li < 4) && k < 20) begin
            @(negedge clk);
            if (k < 8) begin
                check("cont_alu_ready", 32'(bus.o_alu_ready), 32'(exp_alu_rdy[k]));
                check("cont_lsu_ready", 32'(bus.o_lsu_ready), 32'(exp_lsu_rdy[k]));
            end
            ga = bus.o_alu_ready;
            gl = bus.o_lsu_ready;
            tick();
            if (ga) begin
                ai++;
                if (ai < 4) begin
                    bus.i_alu_rd   = 5'(1 + ai);
                    bus.i_alu_data = 32'hA000_0000 + 32'(1 + ai);
                end else begin
                    bus.i_alu_valid = 1'b0;
                end
            end
            if (gl) begin
                li++;
                if (li < 4) begin
                    bus.i_lsu_rd   = 5'(9 + li);
                    bus.i_lsu_data = 32'hB000_0000 + 32'(9 + li);
                end else begin
                    bus.i_lsu_valid = 1'b0;
                end
            end
            k++;
        end
        check("cont_cycles", 32'(k), 32'd8);
        bus.i_alu_valid = 1'b0;
        bus.i_lsu_valid = 1'b0;
        tick();

        // Single ALU write to x5
        issue(5'd5, 1'b0);
        bus.i_r_reg_a   = 5'd5;
        bus.i_alu_valid = 1'b1;
        bus.i_alu_rd    = 5'd5;
        bus.i_alu_data  = 32'hDEAD_BEEF;
        exp_q.push_back(mk(5'd5, 32'hDEAD_BEEF));
        @(negedge clk);
        check("x5_busy_before", 32'(bus.o_busy_a), 32'd1);
        check("x5_alu_ready", 32'(bus.o_alu_ready), 32'd1);
        tick();
        bus.i_alu_valid = 1'b0;
        @(negedge clk);
        check("x5_w_en", 32'(bus.o_w_reg_enable), 32'd1);
        check("x5_busy_after", 32'(bus.o_busy_a), 32'd0);
        tick();

        // Owner mismatch on x7: stale ALU result must not clear the pending load
        issue(5'd7, 1'b0);
        issue(5'd7, 1'b1);
        bus.i_r_reg_b = 5'd7;
        exp_q.push_back(mk(5'd7, 32'h0000_0077));
        alu_wb(5'd7, 32'h0000_0077);
        @(negedge clk);
        check("x7_busy_after_alu", 32'(bus.o_busy_b), 32'd1);
        tick();
        exp_q.push_back(mk(5'd7, 32'h0000_7777));
        lsu_wb(5'd7, 32'h0000_7777);
        @(negedge clk);
        check("x7_busy_after_lsu", 32'(bus.o_busy_b), 32'd0);
        tick();

        // x0: issue ignored, writeback accepted without enable
        issue(5'd0, 1'b1);
        bus.i_r_reg_a   = 5'd0;
        bus.i_lsu_valid = 1'b1;
        bus.i_lsu_rd    = 5'd0;
        bus.i_lsu_data  = 32'h0000_1234;
        @(negedge clk);
        check("x0_busy", 32'(bus.o_busy_a), 32'd0);
        check("x0_lsu_ready", 32'(bus.o_lsu_ready), 32'd1);
        tick();
        bus.i_lsu_valid = 1'b0;
        @(negedge clk);
        check("x0_w_en", 32'(bus.o_w_reg_enable), 32'd0);
        tick();

        // Same-cycle issue (LSU) and ALU clear on x3: issue wins, owner becomes LSU
        issue(5'd3, 1'b0);
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rd    = 5'd3;
        bus.i_issue_src   = 1'b1;
        exp_q.push_back(mk(5'd3, 32'h0000_0033));
        alu_wb(5'd3, 32'h0000_0033);
        bus.i_issue_valid = 1'b0;
        bus.i_r_reg_a     = 5'd3;
        @(negedge clk);
        check("x3_busy_after_race", 32'(bus.o_busy_a), 32'd1);
        tick();
        exp_q.push_back(mk(5'd3, 32'h0000_0333));
        alu_wb(5'd3, 32'h0000_0333);
        @(negedge clk);
        check("x3_owner_is_lsu", 32'(bus.o_busy_a), 32'd1);
        tick();
        exp_q.push_back(mk(5'd3, 32'h0000_3333));
        lsu_wb(5'd3, 32'h0000_3333);
        @(negedge clk);
        check("x3_busy_cleared", 32'(bus.o_busy_a), 32'd0);
        tick();

        // Reset mid-transfer with x9 pending
        issue(5'd9, 1'b1);
        bus.i_r_reg_b = 5'd9;
        @(negedge clk);
        check("x9_busy_pre_reset", 32'(bus.o_busy_b), 32'd1);
        tick();
        alu_wb(5'd2, 32'h0000_00AA);
        check("inflight_w_en", 32'(bus.o_w_reg_enable), 32'd1);
        check("inflight_w_reg", 32'(bus.o_w_reg), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_drops_w_en", 32'(bus.o_w_reg_enable), 32'd0);
        check("reset_clears_busy", 32'(bus.o_busy_b), 32'd0);
        @(negedge clk);
        check("reset_w_reg", 32'(bus.o_w_reg), 32'd0);
        check("reset_w_data", bus.o_w_data, 32'd0);
        tick();
        rst_n = 1'b1;
        check_all_idle_busy();
        repeat (4) @(negedge clk);
        check("no_write_after_reset", 32'(bus.o_w_reg_enable), 32'd0);

        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

- Shares the register file's single write port between the ALU and load/store writeback sources using a round-robin arbiter.
- Keeps a per-register pending-write scoreboard so the decode stage can detect read-after-write hazards on both read ports.
- Sits between the execute/memory stages and the register file; its registered write outputs drive the register file's write port directly.

## Interface
Parameters:
- XLEN, 32, data width of write data.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_issue_valid  in  1  decode issues an instruction that will write rd.
- i_issue_rd  in  5  destination register of issued instruction.
- i_issue_src  in  1  writeback source of issued instruction: 0 = ALU, 1 = LSU.
- i_alu_valid / o_alu_ready  in/out  1  ALU writeback handshake.
- i_alu_rd, i_alu_data  in  5, XLEN  ALU writeback register and value.
- i_lsu_valid / o_lsu_ready  in/out  1  LSU writeback handshake.
- i_lsu_rd, i_lsu_data  in  5, XLEN  LSU writeback register and value.
- o_w_reg_enable  out  1  register file write enable (registered).
- o_w_reg  out  5  register file write address (registered).
- o_w_data  out  XLEN  register file write data (registered).
- i_r_reg_a, i_r_reg_b  in  5  register file read addresses from decode.
- o_busy_a, o_busy_b  out  1  the read register has a pending, uncommitted write.

## Operation
- **Arbitration**
  - o_alu_ready and o_lsu_ready are combinational from the valids and the last_grant flop.
  - Only one source is granted per cycle.
  - If both are valid, the source not granted last time wins.
  - If one is valid, that source wins.
  - A transfer occurs when valid & ready are both high at a rising edge; last_grant then updates to the winner.
  - last_grant resets to LSU, so ALU wins the first tie.
- **Write port**
  - On a transfer, o_w_reg_enable=1 and o_w_reg/o_w_data take the winner's rd/data.
  - With no transfer, o_w_reg_enable=0 and o_w_reg/o_w_data hold their values.
  - A transfer with rd=0 is accepted (ready asserted) but produces o_w_reg_enable=0.
- **Scoreboard**
  - 31 pending bits (x1..x31), each with a 1-bit owner field.
  - Issue with rd≠0 sets pending[rd] and owner[rd]=i_issue_src.
  - Issue with rd=0 is ignored.
  - A transfer with rd≠0 clears pending[rd] only if owner[rd] equals the transferring source; otherwise pending is unchanged. This covers a stale ALU result landing while a later load to the same rd is outstanding.
  - Issue and a clearing transfer to the same rd in the same cycle: the issue wins (pending stays 1, owner = new source).
- **Hazard outputs**
  - o_busy_a = pending[i_r_reg_a]; o_busy_b = pending[i_r_reg_b]; both are combinational.
  - Register address 0 always reports busy=0.
- Requesters hold valid, rd and data stable until ready is seen; the bench checks this with an assertion.

## Timing
- **Reset:**
  - All pending bits = 0, owners = ALU, last_grant = LSU.
  - o_w_reg_enable = 0, o_w_reg = 0, o_w_data = 0.
  - o_busy_a/o_busy_b = 0.
  - Readies follow their combinational equations.
- **Latency:** transfer at edge N drives o_w_* during cycle N..N+1. The register file commits on the falling edge inside that cycle.
- **Busy release:** pending clears at edge N, so busy drops in the same cycle the register file writes. A reader sampling at edge N+1 sees the new value.
- **Throughput:**
  - One write per cycle.
  - Sustained dual valid alternates ALU, LSU, ALU, …
  - No bubble on an uncontested source.
- **Reset mid-operation:** asynchronous clear of all state. An in-flight o_w_reg_enable drops immediately, and no partial write is issued after deassertion.

## Structure
- Shared package rf_pkg:
  - RegAddr (logic [4:0]) and Word (logic [XLEN-1:0]) typedefs.
  - Source enum {SRC_ALU, SRC_LSU}.
  - NUM_REGS = 32.
- One sub-module, rr_arbiter2: two requests in, two one-hot grants out, with its own last_grant flop and an advance input. Scoreboard and write-port registers stay in the top module.

## Test plan
- **Reset:** reset asserted mid-transfer -> o_w_reg_enable=0 immediately; after release, busy_a/busy_b=0 for all addresses.
- **Single ALU write:** issue rd=5 src=ALU, then ALU valid rd=5 data=0xDEADBEEF -> ready same cycle; next cycle o_w_reg_enable=1, o_w_reg=5, o_w_data=0xDEADBEEF; o_busy_a for reg 5 goes 1 then 0.
- **Contention:** both valid for 4 cycles (ALU rd=1..4, LSU rd=9..12) -> grants ALU, LSU, ALU, LSU; writes appear in that order, one per cycle.
- **Owner mismatch:** issue rd=7 ALU, then rd=7 LSU; ALU writeback rd=7 -> pending[7] stays 1; LSU writeback rd=7 -> pending[7] clears.
- **x0 handling:** issue rd=0 -> busy for 0 stays 0; LSU writeback rd=0 data=0x1234 -> ready=1, o_w_reg_enable=0.
- **Simultaneous issue and clear:** issue rd=3 LSU in the same cycle as ALU writeback rd=3 (owner ALU) -> pending[3]=1, owner=LSU afterwards.
